// File: rtl/kamus_mem_lsu.sv
// MEM-stage load/store unit: drives the L1D req/gnt/rvalid handshake, builds lane masks and
// store data, extends load data, and registers the MEM-WB stage.
module kamus_mem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  input  logic [5:0]  operation_i,
  input  logic [31:0] ex_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] next_pc_i,
  input  logic [1:0]  wb_mux_sel_i,
  input  logic        l1d_wr_en_i,
  input  logic        regfile_wr_en_i,
  output logic        stall_o,
  output logic        l1d_req_o,
  output logic        l1d_we_o,
  output logic [31:0] l1d_addr_o,
  output logic [3:0]  l1d_be_o,
  output logic [31:0] l1d_wdata_o,
  input  logic        l1d_gnt_i,
  input  logic        l1d_rvalid_i,
  input  logic [31:0] l1d_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_ex_o,
  output logic [31:0] wb_load_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_next_pc_o,
  output logic [1:0]  wb_mux_sel_o,
  output logic        wb_regfile_wr_en_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam logic [5:0] OP_LB  = 6'h10;
  localparam logic [5:0] OP_LH  = 6'h11;
  localparam logic [5:0] OP_LW  = 6'h12;
  localparam logic [5:0] OP_LBU = 6'h14;
  localparam logic [5:0] OP_LHU = 6'h15;
  localparam logic [5:0] OP_SB  = 6'h18;
  localparam logic [5:0] OP_SH  = 6'h19;
  localparam logic [5:0] OP_SW  = 6'h1A;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] f_size(input logic [5:0] op);
    logic [1:0] sz;
    sz = 2'd0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) sz = 2'd1;
    else if (op == OP_LW || op == OP_SW)            sz = 2'd2;
    return sz;
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'd0:    w = {4{d[7:0]}};
      2'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] f_extract(input logic [5:0] op, input logic [1:0] off,
                                            input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[8*off +: 8];
    h = rd[16*off[1] +: 16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [5:0]         r_op;
  logic [31:0]        r_addr;
  logic               r_we;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [4:0]         r_rd;
  logic [31:0]        r_next_pc;
  logic [1:0]         r_mux_sel;
  logic               r_rf_we;

  logic               r_wb_valid;
  logic [31:0]        r_wb_ex;
  logic [31:0]        r_wb_load;
  logic [4:0]         r_wb_rd;
  logic [31:0]        r_wb_pc;
  logic [1:0]         r_wb_sel;
  logic               r_wb_rf_we;
  logic               r_misaligned;
  logic               r_bus_err;

  logic               w_is_load;
  logic               w_is_store;
  logic               w_is_mem;
  logic [1:0]         w_size;
  logic               w_misaligned;
  logic               w_accept;
  logic               w_mem_accept;
  logic               w_busy;
  logic               w_timeout;
  logic               w_complete;

  assign w_is_load  = (operation_i == OP_LB) || (operation_i == OP_LH) || (operation_i == OP_LW) ||
                      (operation_i == OP_LBU) || (operation_i == OP_LHU);
  assign w_is_store = (operation_i == OP_SB) || (operation_i == OP_SH) || (operation_i == OP_SW);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_size     = f_size(operation_i);
  assign w_misaligned = w_is_mem & (((w_size == 2'd2) & (ex_i[1:0] != 2'b00)) |
                                    ((w_size == 2'd1) & ex_i[0]));

  assign w_accept     = ex_valid_i & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_mem_accept = w_accept & w_is_mem & ~w_misaligned;
  assign w_busy       = (r_state == S_REQ) | (r_state == S_WAIT);
  assign w_timeout    = w_busy & (r_cnt == CNT_W'(TIMEOUT));
  // A timed-out access never completes, even if the bus answers in the abort cycle
  assign w_complete   = ~w_timeout &
                        (((r_state == S_REQ) & l1d_gnt_i & (r_we | l1d_rvalid_i)) |
                         ((r_state == S_WAIT) & l1d_rvalid_i));

  assign stall_o     = w_mem_accept | (w_busy & ~w_complete & ~w_timeout);
  assign l1d_req_o   = (r_state == S_REQ) & ~w_timeout;
  assign l1d_we_o    = r_we;
  assign l1d_addr_o  = {r_addr[31:2], 2'b00};
  assign l1d_be_o    = r_be;
  assign l1d_wdata_o = r_wdata;

  assign wb_valid_o         = r_wb_valid;
  assign wb_ex_o            = r_wb_ex;
  assign wb_load_data_o     = r_wb_load;
  assign wb_rd_addr_o       = r_wb_rd;
  assign wb_next_pc_o       = r_wb_pc;
  assign wb_mux_sel_o       = r_wb_sel;
  assign wb_regfile_wr_en_o = r_wb_rf_we;
  assign misaligned_o       = r_misaligned;
  assign bus_err_o          = r_bus_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_op         <= '0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_rd         <= '0;
      r_next_pc    <= '0;
      r_mux_sel    <= '0;
      r_rf_we      <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_ex      <= '0;
      r_wb_load    <= '0;
      r_wb_rd      <= '0;
      r_wb_pc      <= '0;
      r_wb_sel     <= '0;
      r_wb_rf_we   <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (w_mem_accept) begin
            r_state   <= S_REQ;
            r_op      <= operation_i;
            r_addr    <= ex_i;
            r_we      <= l1d_wr_en_i;
            r_be      <= f_be(w_size, ex_i[1:0]);
            r_wdata   <= f_wdata(w_size, rs2_data_i);
            r_rd      <= rd_addr_i;
            r_next_pc <= next_pc_i;
            r_mux_sel <= wb_mux_sel_i;
            r_rf_we   <= regfile_wr_en_i;
          end else if (w_accept) begin
            // Non-memory or misaligned: straight into MEM-WB, no bus traffic
            r_wb_valid   <= 1'b1;
            r_wb_ex      <= ex_i;
            r_wb_load    <= '0;
            r_wb_rd      <= rd_addr_i;
            r_wb_pc      <= next_pc_i;
            r_wb_sel     <= wb_mux_sel_i;
            r_wb_rf_we   <= regfile_wr_en_i & ~w_misaligned;
            r_misaligned <= w_misaligned;
          end
        end
        S_REQ, S_WAIT: begin
          if (w_complete || w_timeout) begin
            r_state    <= S_DONE;
            r_cnt      <= '0;
            r_wb_valid <= 1'b1;
            r_wb_ex    <= r_addr;
            r_wb_load  <= (w_complete && !r_we) ? f_extract(r_op, r_addr[1:0], l1d_rdata_i) : '0;
            r_wb_rd    <= r_rd;
            r_wb_pc    <= r_next_pc;
            r_wb_sel   <= r_mux_sel;
            r_wb_rf_we <= r_rf_we & ~w_timeout;
            r_bus_err  <= w_timeout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == S_REQ && l1d_gnt_i) r_state <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
